div_iter: RTL and testbench
===========================

# div_iter

Iterative radix-2 restoring divider for the NPC execute stage. It computes quotient and remainder for signed or unsigned integer division using one trial subtraction per cycle, implemented as OP_A + ~OP_B + 1. Results follow RISC-V M-extension semantics. It sits beside the ALU behind a valid/ready handshake on both the request and result sides, and the pipeline can flush it.

## Interface
- DATA_LEN, 32: operand and result width in bits (32 or 64).
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  divider idle and able to accept a request.
- dividend  input  DATA_LEN  numerator.
- divisor  input  DATA_LEN  denominator.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- flush  input  1  abort any operation in flight.
- out_valid  output  1  quotient and remainder valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  DATA_LEN  quotient result.
- remainder  output  DATA_LEN  remainder result.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: iterating.
  - DONE: out_valid=1.
- IDLE→CALC when in_valid && in_ready and the operation is normal.
- IDLE→DONE when in_valid && in_ready and the operation is a special case (divisor==0, or signed overflow). Special cases skip CALC.
- CALC→DONE when the iteration counter reaches DATA_LEN-1.
- DONE→IDLE when out_ready=1.
- Latch on accept:
  - |dividend| and |divisor| when is_signed; raw values otherwise.
  - sign_q = dividend[MSB]^divisor[MSB], sign_r = dividend[MSB]. Both are forced to 0 when unsigned.
- Partial remainder register is DATA_LEN+1 bits; quotient/shift register is DATA_LEN bits; counter is clog2(DATA_LEN) bits, cleared on accept.
- Each CALC cycle:
  - Shift {rem, quo} left by 1.
  - Trial difference = rem - {0,divisor}.
  - If the difference is non-negative (MSB==0): rem ← difference and the new quo LSB ← 1.
  - Otherwise rem is kept and the new quo LSB ← 0.
- Entering DONE:
  - quotient = sign_q ? -quo : quo.
  - remainder = sign_r ? -rem[DATA_LEN-1:0] : rem[DATA_LEN-1:0].
- Divide by zero: quotient = all ones, remainder = dividend. Applies to both signed and unsigned.
- Signed overflow (dividend = 1<<(DATA_LEN-1), divisor = all ones): quotient = dividend, remainder = 0.
- flush:
  - State goes to IDLE on the next edge from any state and out_valid drops. The result is discarded.
  - flush has priority over in_valid and out_ready in the same cycle; a request presented with flush is not accepted.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; out_valid=0; quotient=0, remainder=0; counter=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all work.

## Timing
- in_ready and out_valid are decoded directly from state, with no combinational path from inputs. in_ready=1 only in IDLE.
- Normal latency: accept at edge N, out_valid=1 during cycle N+DATA_LEN+1. That is DATA_LEN CALC cycles plus one cycle to register the result.
- Special-case latency: out_valid=1 during cycle N+1.
- Result handshake: completes at the edge where out_valid && out_ready. The next request can be accepted one cycle after that edge (back in IDLE).
- Backpressure: while out_valid=1 && out_ready=0, quotient and remainder stay stable and in_ready=0.
- Operands only need to be valid in the accept cycle; the divider does not sample them afterwards.
- Throughput (DATA_LEN=32, out_ready held high): one normal division every 34 cycles.

## Test plan
- Unsigned 100/7, DATA_LEN=32: out_valid rises 33 cycles after accept with quotient=14, remainder=2. in_ready=0 throughout.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also check unsigned of the same bits: quotient=0x7FFFFFFC, remainder=1.
- Special cases, each with out_valid one cycle after accept:
  - 5/0 (either mode): quotient=0xFFFFFFFF, remainder=5.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Outputs stay constant, in_ready stays 0, and in_valid pulses are ignored. Raise out_ready: IDLE next cycle.
- flush on the 10th CALC cycle: IDLE next cycle, no out_valid ever. A following 9/3 completes normally with quotient=3, remainder=0.
- rst_n low for one edge mid-CALC: out_valid=0, quotient=0, remainder=0, and in_ready=1 next cycle. A subsequent 0xFFFFFFFF/1 unsigned gives quotient=0xFFFFFFFF, remainder=0.

Source files
------------

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter -- iterative radix-2 restoring divider (RISC-V M semantics)
//
// Computes quotient and remainder of dividend / divisor, signed or unsigned,
// one trial subtraction (rem + ~divisor + 1) per cycle. Divide-by-zero and
// signed overflow are resolved at accept time and skip the iteration.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   divider idle, request will be accepted (IDLE only)
//   dividend   numerator, DATA_LEN bits
//   divisor    denominator, DATA_LEN bits
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   flush      abort whatever is in flight, discard any result
//   out_valid  quotient/remainder valid (DONE only)
//   out_ready  consumer accepts the result
//   quotient   quotient result, DATA_LEN bits
//   remainder  remainder result, DATA_LEN bits
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready and out_valid are decoded from the state register
// only, so neither depends combinationally on any input. Once out_valid is
// high the result holds steady until out_ready is seen (or flush/reset).
// flush wins over in_valid and out_ready in the same cycle.
//
// Timing: accept at edge N; special cases show out_valid right after edge N,
// normal divisions right after edge N+DATA_LEN (DATA_LEN iterations, the last
// of which also registers the sign-corrected result).
// ---------------------------------------------------------------------------
module div_iter #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  input  logic                is_signed,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam int REM_W = DATA_LEN + 1;
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(DATA_LEN - 1);
  localparam logic [DATA_LEN-1:0] MIN_NEG  = {1'b1, {(DATA_LEN-1){1'b0}}};
  localparam logic [DATA_LEN-1:0] ONE      = DATA_LEN'(1);
  localparam logic [REM_W-1:0]    ONE_W    = REM_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // State and datapath registers
  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [REM_W-1:0]    rem_q,       rem_d;
  logic [DATA_LEN-1:0] quo_q,       quo_d;
  logic [DATA_LEN-1:0] dvs_q,       dvs_d;
  logic                neg_quo_q,   neg_quo_d;
  logic                neg_rem_q,   neg_rem_d;
  logic [DATA_LEN-1:0] quotient_q,  quotient_d;
  logic [DATA_LEN-1:0] remainder_q, remainder_d;

  // Accept-side decode
  logic                accept;
  logic                dvd_neg;
  logic                dvs_neg;
  logic [DATA_LEN-1:0] dvd_mag;
  logic [DATA_LEN-1:0] dvs_mag;
  logic                div_zero;
  logic                sgn_ovf;

  // Iteration datapath
  logic [REM_W-1:0]    rem_shift;
  logic [REM_W-1:0]    trial;
  logic                trial_ok;
  logic [REM_W-1:0]    rem_nx;
  logic [DATA_LEN-1:0] quo_nx;
  logic [DATA_LEN-1:0] quo_res;
  logic [DATA_LEN-1:0] rem_res;

  // A request presented together with flush is dropped, not accepted.
  always_comb begin
    accept   = in_valid && (state_q == IDLE) && !flush;
    dvd_neg  = is_signed & dividend[DATA_LEN-1];
    dvs_neg  = is_signed & divisor[DATA_LEN-1];
    dvd_mag  = dvd_neg ? (~dividend + ONE) : dividend;
    dvs_mag  = dvs_neg ? (~divisor  + ONE) : divisor;
    div_zero = (divisor == '0);
    sgn_ovf  = is_signed && (dividend == MIN_NEG) && (divisor == '1);
  end

  // One restoring step: shift {rem, quo} left, try rem - divisor, keep the
  // difference only when it did not go negative (MSB of the wide diff clear).
  always_comb begin
    rem_shift = {rem_q[DATA_LEN-1:0], quo_q[DATA_LEN-1]};
    trial     = rem_shift + ~{1'b0, dvs_q} + ONE_W;
    trial_ok  = ~trial[DATA_LEN];
    rem_nx    = trial_ok ? trial : rem_shift;
    quo_nx    = {quo_q[DATA_LEN-2:0], trial_ok};
    quo_res   = neg_quo_q ? (~quo_nx + ONE) : quo_nx;
    rem_res   = neg_rem_q ? (~rem_nx[DATA_LEN-1:0] + ONE) : rem_nx[DATA_LEN-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (div_zero) begin
            quotient_d  = '1;
            remainder_d = dividend;
            state_d     = DONE;
          end else if (sgn_ovf) begin
            quotient_d  = dividend;
            remainder_d = '0;
            state_d     = DONE;
          end else begin
            quo_d     = dvd_mag;
            dvs_d     = dvs_mag;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == LAST_CNT) begin
          // Final step: register the sign-corrected result directly.
          quotient_d  = quo_res;
          remainder_d = rem_res;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_iter.sv
// ---------------------------------------------------------------------------
// tb_div_iter -- directed bench for div_iter (DATA_LEN = 32).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on
// the rising edge. Expected results are hand-computed constants queued in
// exp_q when a division is launched and popped when the result appears.
// ---------------------------------------------------------------------------
module tb_div_iter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  div_iter #(.DATA_LEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one request for one cycle, then scramble the operand lines so the
  // divider cannot rely on them after the accept edge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    @(negedge clk);
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
  endtask

  // Cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int lat, output bit rdy_seen);
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " idle after handshake"}, {30'd0, out_valid, in_ready}, 32'h1);
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int exp_lat);
    int lat;
    bit rdy_seen;
    exp_q.push_back(eq);
    exp_q.push_back(er);
    start(a, b, sgn);
    wait_out(lat, rdy_seen);
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    if (exp_lat > 1) check({tag, " in_ready while busy"}, {31'd0, rdy_seen}, 32'd0);
    check({tag, " quotient"},  quotient,  exp_q.pop_front());
    check({tag, " remainder"}, remainder, exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  lat;
    bit  rdy_seen;
    bit  seen;
    logic [W-1:0] hold_q;
    logic [W-1:0] hold_r;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset quotient",  quotient,  32'd0);
    check("reset remainder", remainder, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal divisions
    run_div("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
    take_result("u100/7");
    run_div("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    take_result("s-7/2");
    run_div("uFFFFFFF9/2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 33);
    take_result("uFFFFFFF9/2");
    run_div("s-100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
    take_result("s-100/7");
    run_div("s100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 33);
    take_result("s100/-7");
    run_div("u3/10", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 33);
    take_result("u3/10");
    run_div("u80000000/FFFFFFFF", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 33);
    take_result("u80000000/FFFFFFFF");

    // Special cases
    run_div("u5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1);
    take_result("u5/0");
    run_div("s5/0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1);
    take_result("s5/0");
    run_div("s-5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1);
    take_result("s-5/0");
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1);
    take_result("s_ovf");

    // Backpressure: result holds, in_ready low, in_valid pulses ignored
    run_div("bp1000/10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 33);
    hold_q = quotient;
    hold_r = remainder;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      dividend = 32'd5;
      divisor  = 32'd0;
      @(negedge clk);
      check("bp quotient stable",  quotient,  hold_q);
      check("bp remainder stable", remainder, hold_r);
      check("bp valid/ready", {30'd0, out_valid, in_ready}, 32'h2);
    end
    in_valid = 1'b0;
    take_result("bp");
    @(negedge clk);
    check("bp no stray accept", {30'd0, out_valid, in_ready}, 32'h1);

    // Flush on the 10th CALC cycle
    start(32'd50000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush calc idle", {30'd0, out_valid, in_ready}, 32'h1);
    check("flush calc state", {30'd0, dbg_state}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("flush no out_valid", {31'd0, seen}, 32'd0);
    run_div("u9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);
    take_result("u9/3");

    // Flush while holding a result
    start(32'd20, 32'd4, 1'b0);
    wait_out(lat, rdy_seen);
    check("flush done latency", W'(lat), 32'd33);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush done idle", {30'd0, out_valid, in_ready}, 32'h1);

    // Request together with flush is not accepted
    in_valid = 1'b1;
    flush    = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd0;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush beats in_valid", {30'd0, out_valid, in_ready}, 32'h1);
    @(negedge clk);
    check("flush beats in_valid later", {30'd0, out_valid, in_ready}, 32'h1);

    // Put a nonzero result on the outputs, then reset mid-CALC
    run_div("u21/4", 32'd21, 32'd4, 1'b0, 32'd5, 32'd1, 33);
    take_result("u21/4");
    start(32'd12345, 32'd6, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst mid out_valid", {31'd0, out_valid}, 32'd0);
    check("rst mid quotient",  quotient,  32'd0);
    check("rst mid remainder", remainder, 32'd0);
    check("rst mid in_ready",  {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("rst no out_valid", {31'd0, seen}, 32'd0);
    run_div("uFFFFFFFF/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33);
    take_result("uFFFFFFFF/1");

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
